// File: rtl/conv_layer_window_shifter.sv
// Replays the three buffered input rows to the PE kernel bus as 0/1/2-element shifted windows.
// Define CONV_BIAS_BEAT_EN to append an all-FLOAT32_ONE bias beat after every output row.
module conv_layer_window_shifter #(
  parameter int                    INPUT_SIZE  = 8,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    KERNEL_SIZE = 3,
  parameter logic [DATA_WIDTH-1:0] FLOAT32_ONE = 32'h3F80_0000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             enable,
  input  logic                             buffer_ack,
  input  logic [INPUT_SIZE*DATA_WIDTH-1:0] row_bus_in,
  output logic [1:0]                       array_idx,
  output logic [1:0]                       buffer_cmd,
  output logic [INPUT_SIZE*DATA_WIDTH-1:0] kernel_bus_out,
  output logic                             out_valid,
  output logic                             busy,
  output logic                             done
);

  localparam int                BUS_W    = INPUT_SIZE * DATA_WIDTH;
  localparam int                OW       = $clog2(INPUT_SIZE - KERNEL_SIZE + 1);
  localparam logic [1:0]        K_LAST   = 2'(KERNEL_SIZE - 1);
  localparam logic [OW-1:0]     OUT_LAST = OW'(INPUT_SIZE - KERNEL_SIZE);
  localparam logic [BUS_W-1:0]  BIAS_BUS = {INPUT_SIZE{FLOAT32_ONE}};
  localparam logic [1:0]        CMD_IDLE = 2'd0;
  localparam logic [1:0]        CMD_LOAD = 2'd1;
  localparam logic [1:0]        CMD_READ = 2'd2;
`ifdef CONV_BIAS_BEAT_EN
  localparam bit                BIAS_EN  = 1'b1;
`else
  localparam bit                BIAS_EN  = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_ROW, S_BIAS, S_LOAD, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        row_cnt_q, row_cnt_d;
  logic [1:0]        shift_cnt_q, shift_cnt_d;
  logic [OW-1:0]     out_row_q, out_row_d;
  logic [BUS_W-1:0]  kbus_q, kbus_d;
  logic              valid_q, valid_d;
  logic              row_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_cnt_q   <= '0;
      shift_cnt_q <= '0;
      out_row_q   <= '0;
      kbus_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      out_row_q   <= out_row_d;
      kbus_q      <= kbus_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    shift_cnt_d = shift_cnt_q;
    out_row_d   = out_row_q;
    kbus_d      = kbus_q;
    valid_d     = valid_q;
    row_end     = 1'b0;
    if (enable) begin
      case (state_q)
        S_IDLE: begin
          valid_d = 1'b0;
          if (start) begin
            state_d     = S_ROW;
            row_cnt_d   = '0;
            shift_cnt_d = '0;
            out_row_d   = '0;
          end
        end
        S_ROW: begin
          valid_d = 1'b1;
          if (shift_cnt_q == 2'd0) kbus_d = row_bus_in;
          else kbus_d = {kbus_q[BUS_W-DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
          if (shift_cnt_q == K_LAST) begin
            shift_cnt_d = '0;
            if (row_cnt_q == K_LAST) begin
              row_cnt_d = '0;
              if (BIAS_EN) state_d = S_BIAS;
              else row_end = 1'b1;
            end else begin
              row_cnt_d = row_cnt_q + 2'd1;
            end
          end else begin
            shift_cnt_d = shift_cnt_q + 2'd1;
          end
        end
        S_BIAS: begin
          kbus_d  = BIAS_BUS;
          valid_d = 1'b1;
          row_end = 1'b1;
        end
        S_LOAD: begin
          valid_d = 1'b0;
          if (buffer_ack) begin
            state_d     = S_ROW;
            row_cnt_d   = '0;
            shift_cnt_d = '0;
          end
        end
        S_DONE: begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      // Last beat of an output row: either finish the image or fetch the next input row.
      if (row_end) begin
        if (out_row_q == OUT_LAST) begin
          state_d = S_DONE;
        end else begin
          out_row_d = out_row_q + 1'b1;
          state_d   = S_LOAD;
        end
      end
    end
  end

  always_comb begin
    array_idx  = (state_q == S_ROW) ? row_cnt_q : 2'd3;
    case (state_q)
      S_ROW:   buffer_cmd = CMD_READ;
      S_LOAD:  buffer_cmd = CMD_LOAD;
      default: buffer_cmd = CMD_IDLE;
    endcase
  end

  assign kernel_bus_out = kbus_q;
  assign out_valid      = valid_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_layer_window_shifter.sv
// Scoreboard bench for conv_layer_window_shifter with a behavioural row-buffer model.
module tb_conv_layer_window_shifter;

  localparam int N        = 8;
  localparam int W        = 32;
  localparam int K        = 3;
  localparam int BUS_W    = N * W;
  localparam int OUT_ROWS = N - K + 1;
`ifdef CONV_BIAS_BEAT_EN
  localparam int BEATS_ROW = K * K + 1;
`else
  localparam int BEATS_ROW = K * K;
`endif
  localparam int             BEATS_IMG = BEATS_ROW * OUT_ROWS;
  localparam logic [W-1:0]   ONE_F     = 32'h3F80_0000;

  logic             clk = 1'b0;
  logic             rst_n, start, enable, buffer_ack;
  logic [BUS_W-1:0] row_bus_in, kernel_bus_out;
  logic [1:0]       array_idx, buffer_cmd;
  logic             out_valid, busy, done;

  logic [BUS_W-1:0] buf_rows [4];
  logic [BUS_W-1:0] sb_q [$];
  int n_checks  = 0;
  int n_fail    = 0;
  int img_beats = 0;
  int done_cnt  = 0;
  int ack_delay = 1;
  int long_acks = 0;
  int next_load = 3;

  conv_layer_window_shifter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .enable         (enable),
    .buffer_ack     (buffer_ack),
    .row_bus_in     (row_bus_in),
    .array_idx      (array_idx),
    .buffer_cmd     (buffer_cmd),
    .kernel_bus_out (kernel_bus_out),
    .out_valid      (out_valid),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  assign row_bus_in = buf_rows[array_idx];

  task automatic check_eq(string tag, logic [BUS_W-1:0] act, logic [BUS_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Image row r shifted left by s elements; element i holds r*N+i, element 0 in the MSBs.
  function automatic logic [BUS_W-1:0] img_beat(int r, int s);
    logic [BUS_W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      if (i + s < N) v[BUS_W-1-i*W -: W] = W'(r * N + i + s);
    return v;
  endfunction

  task automatic push_out_row(int base);
    for (int r = 0; r < K; r++)
      for (int s = 0; s < K; s++)
        sb_q.push_back(img_beat(base + r, s));
`ifdef CONV_BIAS_BEAT_EN
    sb_q.push_back({N{ONE_F}});
`endif
  endtask

  task automatic init_buffer();
    for (int i = 0; i < K; i++) buf_rows[i] = img_beat(i, 0);
    buf_rows[3] = '0;
    next_load = K;
  endtask

  task automatic check_reset_outputs(string pfx);
    check_eq({pfx, "_kbus"},  kernel_bus_out,     '0);
    check_eq({pfx, "_valid"}, BUS_W'(out_valid),  BUS_W'(0));
    check_eq({pfx, "_done"},  BUS_W'(done),       BUS_W'(0));
    check_eq({pfx, "_busy"},  BUS_W'(busy),       BUS_W'(0));
    check_eq({pfx, "_cmd"},   BUS_W'(buffer_cmd), BUS_W'(0));
    check_eq({pfx, "_idx"},   BUS_W'(array_idx),  BUS_W'(3));
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done) done_cnt++;
        if (out_valid && enable) begin
          if (sb_q.size() == 0) check_eq("sb_underflow", BUS_W'(sb_q.size()), BUS_W'(1));
          else begin
            check_eq($sformatf("beat%0d", img_beats), kernel_bus_out, sb_q.pop_front());
            img_beats++;
          end
        end else if (out_valid && sb_q.size() > 0) begin
          check_eq("stall_hold", kernel_bus_out, sb_q[0]);
        end
      end
    end
  end

  initial begin : buffer_model
    int d_lim;
    buffer_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && buffer_cmd == 2'd1) begin
        d_lim = (long_acks > 0) ? 5 : ack_delay;
        if (long_acks > 0) long_acks--;
        for (int d = 0; d < d_lim; d++) begin
          @(negedge clk);
          check_eq("load_hold", BUS_W'(buffer_cmd), BUS_W'(1));
          check_eq("load_no_valid", BUS_W'(out_valid), BUS_W'(0));
        end
        buf_rows[0] = buf_rows[1];
        buf_rows[1] = buf_rows[2];
        buf_rows[2] = img_beat(next_load, 0);
        push_out_row(next_load - K + 1);
        next_load++;
        buffer_ack = 1'b1;
        @(posedge clk);
        #1 buffer_ack = 1'b0;
        @(negedge clk);
        check_eq("row_resume", BUS_W'(buffer_cmd), BUS_W'(2));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst_n  = 1'b0;
    start  = 1'b0;
    enable = 1'b1;
    init_buffer();
    #12;
    check_reset_outputs("por");
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset asserted mid-row while a beat is valid.
    @(posedge clk); #1 start = 1'b1;
    push_out_row(0);
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 20 && !out_valid; c++) begin @(posedge clk); #1; end
    repeat (2) begin @(posedge clk); #1; end
    check_eq("a_valid_before_rst", BUS_W'(out_valid), BUS_W'(1));
    check_eq("a_cmd_before_rst", BUS_W'(buffer_cmd), BUS_W'(2));
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_eq("a_idle_busy", BUS_W'(busy), BUS_W'(0));
    check_eq("a_idle_valid", BUS_W'(out_valid), BUS_W'(0));
    check_eq("a_idle_cmd", BUS_W'(buffer_cmd), BUS_W'(0));

    // Full image; first load acknowledged late, the rest after one cycle.
    init_buffer();
    img_beats = 0;
    done_cnt  = 0;
    long_acks = 1;
    ack_delay = 1;
    @(posedge clk); #1 start = 1'b1;
    push_out_row(0);
    @(posedge clk); #1 start = 1'b0;
    check_eq("b_busy_after_start", BUS_W'(busy), BUS_W'(1));
    check_eq("b_cmd_read", BUS_W'(buffer_cmd), BUS_W'(2));
    check_eq("b_idx_row0", BUS_W'(array_idx), BUS_W'(0));
    check_eq("b_no_valid_yet", BUS_W'(out_valid), BUS_W'(0));
    @(posedge clk); #1;
    check_eq("b_first_beat_valid", BUS_W'(out_valid), BUS_W'(1));
    for (int c = 0; c < 1000 && !done; c++) @(negedge clk);
    check_eq("b_done_seen", BUS_W'(done), BUS_W'(1));
    @(negedge clk);
    check_eq("b_done_pulse", BUS_W'(done), BUS_W'(0));
    check_eq("b_busy_after", BUS_W'(busy), BUS_W'(0));
    repeat (3) @(negedge clk);
    check_eq("b_beats", BUS_W'(img_beats), BUS_W'(BEATS_IMG));
    check_eq("b_done_count", BUS_W'(done_cnt), BUS_W'(1));
    check_eq("b_sb_empty", BUS_W'(sb_q.size()), BUS_W'(0));

    // Image with a 3-cycle enable stall at beat 4; acks answered immediately.
    init_buffer();
    img_beats = 0;
    done_cnt  = 0;
    long_acks = 0;
    ack_delay = 0;
    @(posedge clk); #1 start = 1'b1;
    push_out_row(0);
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (out_valid && img_beats == 4) break;
    end
    check_eq("c_stall_point", BUS_W'(img_beats), BUS_W'(4));
    enable = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("c_frozen_bus", kernel_bus_out, img_beat(1, 1));
      check_eq("c_frozen_valid", BUS_W'(out_valid), BUS_W'(1));
      check_eq("c_frozen_cmd", BUS_W'(buffer_cmd), BUS_W'(2));
    end
    enable = 1'b1;
    for (int c = 0; c < 1000 && !done; c++) @(negedge clk);
    check_eq("c_done_seen", BUS_W'(done), BUS_W'(1));
    repeat (3) @(negedge clk);
    check_eq("c_beats", BUS_W'(img_beats), BUS_W'(BEATS_IMG));
    check_eq("c_done_count", BUS_W'(done_cnt), BUS_W'(1));
    check_eq("c_busy_after", BUS_W'(busy), BUS_W'(0));
    check_eq("c_sb_empty", BUS_W'(sb_q.size()), BUS_W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_layer_window_shifter.md
# conv_layer_window_shifter

Downstream consumer of the conv-layer input buffer: reads the three buffered rows through the buffer's row-select port and replays each row to the PE kernel bus as a shifting window. Each row is shifted 0, 1 and 2 elements, followed by an optional bias beat of all-ones. After every output row it commands the buffer to load the next input row and waits for its acknowledge. It repeats until all output rows of the image are produced.

## Interface
- `INPUT_SIZE`, 8, elements per row and image height.
- `DATA_WIDTH`, 32, element width (float32).
- `KERNEL_SIZE`, 3, kernel rows and shifts per row.
- `FLOAT32_ONE`, 32'h3F80_0000, bias-beat element value.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin an image; sampled only in IDLE.
- `enable` in 1: downstream ready; low freezes all state, counters and outputs.
- `buffer_ack` in 1: buffer has finished loading the requested row.
- `row_bus_in` in INPUT_SIZE*DATA_WIDTH: row selected by `array_idx`, combinational from the buffer.
- `array_idx` out 2: buffer row select. Equals `row_cnt` in ROW, otherwise 2'd3.
- `buffer_cmd` out 2: 0 IDLE, 1 LOAD, 2 READ.
- `kernel_bus_out` out INPUT_SIZE*DATA_WIDTH: registered window to the PE array. Element 0 is in the MSBs.
- `out_valid` out 1: registered; high when `kernel_bus_out` carries a beat.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse after the last beat of the image.

## Operation
- States: IDLE, ROW, BIAS, LOAD, DONE.
- Counters:
  - `row_cnt` 0..KERNEL_SIZE-1.
  - `shift_cnt` 0..KERNEL_SIZE-1.
  - `out_row_cnt` 0..INPUT_SIZE-KERNEL_SIZE (6 output rows at the defaults).
- IDLE: when `start` is high, go to ROW and clear all counters. `buffer_cmd` = IDLE.
- ROW: `buffer_cmd` = READ.
  - At `shift_cnt`=0, capture `row_bus_in` into `kernel_bus_out`.
  - Otherwise shift left one element: out[N*W-1:W] <= out[(N-1)*W-1:0]; the LSB element is zero-filled.
  - `shift_cnt` wraps after KERNEL_SIZE-1, then `row_cnt` increments. When `row_cnt` wraps, go to BIAS (go to LOAD/DONE directly when the bias beat is compiled out).
- BIAS: load every element with FLOAT32_ONE, `out_valid`=1.
  - If `out_row_cnt` = last, go to DONE.
  - Otherwise increment `out_row_cnt` and go to LOAD.
- LOAD: `buffer_cmd` = LOAD, held until `buffer_ack`; `out_valid`=0.
  - On `buffer_ack`, go to ROW with counters cleared.
  - `buffer_ack` that is already high on LOAD entry is accepted in that cycle.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` is ignored while `busy`. `buffer_ack` is ignored outside LOAD.
- `enable`=0 holds state, counters, `kernel_bus_out`, `out_valid` and `buffer_cmd` unchanged. `done` is held if it is already asserted.

## Timing
- Reset values:
  - State IDLE, all counters 0.
  - `kernel_bus_out` 0, `out_valid` 0, `done` 0, `busy` 0.
  - `buffer_cmd` 0, `array_idx` 2'd3.
- Reset asserted mid-operation returns to IDLE immediately (asynchronous). Outputs go to their reset values.
- `start` sampled at edge k: state is ROW from k; the first beat is valid after edge k+1.
- Per output row with `enable` held high: 9 ROW beats + 1 BIAS beat = 10 consecutive valid cycles, then LOAD for at least 1 cycle.
- `array_idx` and `buffer_cmd` are decoded combinationally from state and counters, with no output register.
- `done` asserts in the cycle after the final BIAS beat.

## Configuration
- `CONV_BIAS_BEAT_EN` defined: BIAS state present; 10 beats per output row; the last beat is all FLOAT32_ONE.
- Not defined: BIAS state removed; ROW goes straight to LOAD or DONE; 9 beats per output row.
- The macro changes nothing else.

## Test plan
- **Reset:** assert `rst_n`=0 mid-ROW with `out_valid`=1 → all outputs at reset values the same cycle; the FSM sits in IDLE after release.
- **Single row:** preload rows 0..2 with element values r*8+i, `start` pulse, `enable`=1.
  - Beat 0 → {0,1,..,7}.
  - Beat 1 → {1,..,7,0}.
  - Beat 2 → {2,..,7,0,0}.
  - Beats 3..8 repeat the pattern for rows 1 and 2.
  - Beat 9 → all 32'h3F800000.
- **Load handshake:** after the first BIAS beat → `buffer_cmd`=1 held. Delay `buffer_ack` by 5 cycles → no `out_valid` during the wait; ROW resumes the cycle after the ack.
- **Full image:** ack each LOAD after 1 cycle → exactly 60 valid beats, `done` one cycle, `busy` low afterwards.
- **Stall:** drop `enable` for 3 cycles at beat 4 → `kernel_bus_out` frozen at beat 4; the sequence resumes unchanged.
- **Config off:** build without `CONV_BIAS_BEAT_EN` → 54 beats per image and no FLOAT32_ONE beat.
